// File: rtl/ball_control.sv
// rtl/ball_control.sv - ball direction, bounce, scoring and serve control for the ball position stage
module ball_control #(
  parameter int SCREEN_W    = 640,
  parameter int SCREEN_H    = 480,
  parameter int BALL_R      = 4,
  parameter int PAD_L_FACE  = 20,
  parameter int PAD_R_FACE  = 620,
  parameter int PAD_HALF    = 32,
  parameter int SERVE_DELAY = 60,
  parameter int WIN_SCORE   = 9
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       move_tick,
  input  logic       serve,
  input  logic [9:0] ball_center_x,
  input  logic [9:0] ball_center_y,
  input  logic [9:0] paddle_left_y,
  input  logic [9:0] paddle_right_y,
  output logic [3:0] cw_ballMovement,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic       point_scored,
  output logic       game_over
);

  localparam int CNT_W = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;

  localparam logic [10:0] R_W      = 11'(BALL_R);
  localparam logic [10:0] BOT_LIM  = 11'(SCREEN_H - 1);
  localparam logic [10:0] RGT_LIM  = 11'(SCREEN_W - 1);
  localparam logic [10:0] PADL_LIM = 11'(PAD_L_FACE + BALL_R);
  localparam logic [10:0] PADR_LIM = 11'(PAD_R_FACE);
  localparam logic [10:0] ALIGN    = 11'(PAD_HALF + BALL_R);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SERVE_DELAY - 1);

  localparam logic [3:0] CW_HOLD     = 4'b0000;
  localparam logic [3:0] CW_RECENTRE = 4'b0101;

  typedef enum logic [1:0] {IDLE, MOVING, SCORED, GAME_OVER} state_t;

  state_t           state, state_nxt;
  logic             dx, dy, dx_nxt, dy_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             right_scored, right_scored_nxt;
  logic [3:0]       sl_nxt, sr_nxt, cw_nxt;
  logic             pt_nxt;

  function automatic logic [3:0] encode(input logic dx_i, input logic dy_i);
    case ({dx_i, dy_i})
      2'b11:   encode = 4'b0001;
      2'b00:   encode = 4'b0010;
      2'b01:   encode = 4'b0011;
      default: encode = 4'b0100;
    endcase
  endfunction

  // Geometry on the pre-move position, widened so x+R never wraps
  logic [10:0] x_w, y_w;
  logic [9:0]  dist_l, dist_r;
  logic        at_bottom, at_top, near_l, near_r, align_l, align_r, edge_l, edge_r;
  logic        bounce_l, bounce_r, dy_new, dx_new;
  logic        mv_tick, scr_l, scr_r;
  logic [3:0]  sl_inc, sr_inc;

  assign x_w       = {1'b0, ball_center_x};
  assign y_w       = {1'b0, ball_center_y};
  assign dist_l    = (ball_center_y >= paddle_left_y)  ? ball_center_y - paddle_left_y
                                                       : paddle_left_y - ball_center_y;
  assign dist_r    = (ball_center_y >= paddle_right_y) ? ball_center_y - paddle_right_y
                                                       : paddle_right_y - ball_center_y;
  assign at_bottom = (y_w + R_W) >= BOT_LIM;
  assign at_top    = y_w <= R_W;
  assign near_l    = x_w <= PADL_LIM;
  assign near_r    = (x_w + R_W) >= PADR_LIM;
  assign align_l   = {1'b0, dist_l} <= ALIGN;
  assign align_r   = {1'b0, dist_r} <= ALIGN;
  assign edge_l    = x_w <= R_W;
  assign edge_r    = (x_w + R_W) >= RGT_LIM;
  assign bounce_l  = !dx && near_l && align_l;
  assign bounce_r  = dx && near_r && align_r;

  assign dy_new = dy ? !at_bottom : at_top;
  assign dx_new = dx ? !bounce_r : bounce_l;

  assign mv_tick = (state == MOVING) && move_tick;
  assign scr_r   = mv_tick && !dx && !bounce_l && edge_l;
  assign scr_l   = mv_tick && dx && !bounce_r && edge_r;
  assign sl_inc  = (score_left  == 4'hF) ? 4'hF : score_left  + 4'd1;
  assign sr_inc  = (score_right == 4'hF) ? 4'hF : score_right + 4'd1;

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      dx              <= 1'b1;
      dy              <= 1'b1;
      cnt             <= '0;
      right_scored    <= 1'b0;
      score_left      <= 4'd0;
      score_right     <= 4'd0;
      cw_ballMovement <= CW_HOLD;
      point_scored    <= 1'b0;
    end else begin
      state           <= state_nxt;
      dx              <= dx_nxt;
      dy              <= dy_nxt;
      cnt             <= cnt_nxt;
      right_scored    <= right_scored_nxt;
      score_left      <= sl_nxt;
      score_right     <= sr_nxt;
      cw_ballMovement <= cw_nxt;
      point_scored    <= pt_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (serve) state_nxt = MOVING;
      MOVING: begin
        if (scr_l)      state_nxt = (sl_inc == 4'(WIN_SCORE)) ? GAME_OVER : SCORED;
        else if (scr_r) state_nxt = (sr_inc == 4'(WIN_SCORE)) ? GAME_OVER : SCORED;
      end
      SCORED:    if (move_tick && cnt == CNT_LAST) state_nxt = MOVING;
      GAME_OVER: if (serve) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Datapath next values; cw defaults to hold so every nonzero word lasts one cycle
  always_comb begin
    dx_nxt           = dx;
    dy_nxt           = dy;
    cnt_nxt          = cnt;
    right_scored_nxt = right_scored;
    sl_nxt           = score_left;
    sr_nxt           = score_right;
    cw_nxt           = CW_HOLD;
    pt_nxt           = 1'b0;
    case (state)
      MOVING: begin
        if (move_tick) begin
          dy_nxt = dy_new;
          if (scr_l || scr_r) begin
            sl_nxt           = scr_l ? sl_inc : score_left;
            sr_nxt           = scr_r ? sr_inc : score_right;
            right_scored_nxt = scr_r;
            pt_nxt           = 1'b1;
            cw_nxt           = CW_RECENTRE;
            cnt_nxt          = '0;
          end else begin
            dx_nxt = dx_new;
            cw_nxt = encode(dx_new, dy_new);
          end
        end
      end
      SCORED: begin
        if (move_tick) begin
          if (cnt == CNT_LAST) begin
            // Serve toward whoever conceded
            dx_nxt  = !right_scored;
            cnt_nxt = '0;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      GAME_OVER: begin
        if (serve) begin
          sl_nxt = 4'd0;
          sr_nxt = 4'd0;
          dx_nxt = 1'b1;
          dy_nxt = 1'b1;
          cw_nxt = CW_RECENTRE;
        end
      end
      default: ;
    endcase
  end

  // Outputs
  always_comb begin
    game_over = (state == GAME_OVER);
  end

endmodule

// File: tb/tb_ball_control.sv
// tb/tb_ball_control.sv - self-checking bench for ball_control
module tb_ball_control;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       move_tick = 1'b0;
  logic       serve = 1'b0;
  logic [9:0] ball_center_x = 10'd320;
  logic [9:0] ball_center_y = 10'd220;
  logic [9:0] paddle_left_y = 10'd100;
  logic [9:0] paddle_right_y = 10'd100;
  logic [3:0] cw_ballMovement;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic       point_scored;
  logic       game_over;

  ball_control dut (
    .clk(clk),
    .reset_n(reset_n),
    .move_tick(move_tick),
    .serve(serve),
    .ball_center_x(ball_center_x),
    .ball_center_y(ball_center_y),
    .paddle_left_y(paddle_left_y),
    .paddle_right_y(paddle_right_y),
    .cw_ballMovement(cw_ballMovement),
    .score_left(score_left),
    .score_right(score_right),
    .point_scored(point_scored),
    .game_over(game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cw;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       pt;
    logic       go;
    string      nm;
  } exp_t;

  typedef struct {
    logic [9:0] x, y, pl, pr;
    logic [3:0] cw;
    logic       lsc;
    string      nm;
  } vec_t;

  exp_t       sb[$];
  vec_t       vt[9];
  int         checks = 0;
  int         errors = 0;
  logic [3:0] e_sl = 4'd0;
  logic [3:0] e_sr = 4'd0;

  // One clock: drive on the falling edge, queue the expectation, compare just after the rising edge
  task automatic cyc(input logic tk, input logic sv, input logic [3:0] ecw,
                     input logic ept, input logic ego, input string nm);
    exp_t e;
    @(negedge clk);
    move_tick = tk;
    serve     = sv;
    e.cw = ecw; e.sl = e_sl; e.sr = e_sr; e.pt = ept; e.go = ego; e.nm = nm;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    checks++;
    if (cw_ballMovement !== e.cw || score_left !== e.sl || score_right !== e.sr ||
        point_scored !== e.pt || game_over !== e.go) begin
      errors++;
      $display("FAIL %s: got cw=%b sl=%0d sr=%0d pt=%b go=%b, want cw=%b sl=%0d sr=%0d pt=%b go=%b",
               e.nm, cw_ballMovement, score_left, score_right, point_scored, game_over,
               e.cw, e.sl, e.sr, e.pt, e.go);
    end
    move_tick = 1'b0;
    serve     = 1'b0;
  endtask

  task automatic do_reset(input logic tk, input string nm);
    e_sl = 4'd0;
    e_sr = 4'd0;
    reset_n = 1'b0;
    cyc(tk, 1'b0, 4'b0000, 1'b0, 1'b0, nm);
    reset_n = 1'b1;
  endtask

  task automatic set_ball(input int x, input int y, input int pl, input int pr);
    ball_center_x  = 10'(x);
    ball_center_y  = 10'(y);
    paddle_left_y  = 10'(pl);
    paddle_right_y = 10'(pr);
  endtask

  // Sixty ticks of hold after a point; one tick carries serve, which must be ignored
  task automatic serve_delay(input string nm);
    for (int i = 0; i < 60; i++)
      cyc(1'b1, (i == 10), 4'b0000, 1'b0, 1'b0, nm);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0] = '{10'd320, 10'd220, 10'd100, 10'd100, 4'b0001, 1'b0, "free_move"};
    vt[1] = '{10'd320, 10'd475, 10'd100, 10'd100, 4'b0100, 1'b0, "bottom_wall"};
    vt[2] = '{10'd320, 10'd474, 10'd100, 10'd100, 4'b0001, 1'b0, "near_bottom"};
    vt[3] = '{10'd616, 10'd100, 10'd100, 10'd100, 4'b0011, 1'b0, "right_pad_mid"};
    vt[4] = '{10'd616, 10'd100, 10'd100, 10'd136, 4'b0011, 1'b0, "right_pad_edge"};
    vt[5] = '{10'd616, 10'd100, 10'd100, 10'd137, 4'b0001, 1'b0, "right_pad_miss"};
    vt[6] = '{10'd616, 10'd475, 10'd100, 10'd475, 4'b0010, 1'b0, "right_corner"};
    vt[7] = '{10'd635, 10'd100, 10'd100, 10'd400, 4'b0101, 1'b1, "left_point"};
    vt[8] = '{10'd615, 10'd100, 10'd100, 10'd100, 4'b0001, 1'b0, "before_pad"};

    do_reset(1'b0, "reset_state");

    for (int v = 0; v < 9; v++) begin
      do_reset(1'b0, {vt[v].nm, "_reset"});
      cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, {vt[v].nm, "_serve"});
      set_ball(vt[v].x, vt[v].y, vt[v].pl, vt[v].pr);
      if (vt[v].lsc) e_sl = 4'd1;
      cyc(1'b1, 1'b0, vt[v].cw, vt[v].lsc, 1'b0, vt[v].nm);
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, {vt[v].nm, "_hold"});
    end

    // Idle ignores ticks, and a tick alongside serve; then 200 straight moves
    do_reset(1'b0, "b_reset");
    set_ball(320, 220, 100, 100);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "idle_tick");
    cyc(1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, "serve_with_tick");
    for (int i = 0; i < 200; i++) begin
      cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "run_move");
      cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "run_hold");
    end

    // Left paddle bounce, then a miss on the left, serve delay and leftward serve
    do_reset(1'b0, "c_reset");
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "c_serve");
    set_ball(616, 100, 100, 100);
    cyc(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, "c_right_bounce1");
    set_ball(24, 300, 310, 100);
    cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "c_left_bounce");
    set_ball(616, 100, 310, 100);
    cyc(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, "c_right_bounce2");
    set_ball(24, 300, 400, 100);
    cyc(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, "c_left_miss_cont");
    set_ball(4, 300, 400, 100);
    e_sr = 4'd1;
    cyc(1'b1, 1'b0, 4'b0101, 1'b1, 1'b0, "c_right_point");
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "c_point_end");
    serve_delay("c_delay");
    set_ball(320, 220, 400, 100);
    cyc(1'b1, 1'b0, 4'b0011, 1'b0, 1'b0, "c_serve_left");

    // Reset in the middle of play, with a tick present
    do_reset(1'b1, "mid_reset");
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "post_reset_serve");
    cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "post_reset_dir");

    // Wall and paddle together on the left side
    do_reset(1'b0, "d_reset");
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "d_serve");
    set_ball(616, 475, 100, 475);
    cyc(1'b1, 1'b0, 4'b0010, 1'b0, 1'b0, "d_to_left_up");
    set_ball(24, 4, 4, 475);
    cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "d_corner_flip");

    // Left player runs to the winning score
    do_reset(1'b0, "e_reset");
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "e_serve");
    set_ball(635, 100, 100, 400);
    for (int p = 1; p <= 9; p++) begin
      e_sl = 4'(p);
      cyc(1'b1, 1'b0, 4'b0101, 1'b1, (p == 9), "e_point");
      if (p < 9) serve_delay("e_delay");
    end
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b1, "e_over_hold");
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, "e_over_tick");
    e_sl = 4'd0;
    cyc(1'b0, 1'b1, 4'b0101, 1'b0, 1'b0, "e_restart");
    cyc(1'b0, 1'b0, 4'b0000, 1'b0, 1'b0, "e_restart_hold");
    set_ball(320, 220, 100, 100);
    cyc(1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, "e_idle_tick");
    cyc(1'b0, 1'b1, 4'b0000, 1'b0, 1'b0, "e_serve2");
    cyc(1'b1, 1'b0, 4'b0001, 1'b0, 1'b0, "e_new_game_dir");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
